// File: rtl/naneye_pixel_packer_if.sv
// Packed word stream from the NanEye pixel packer to the host-interface writer.
//
// Handshake: the master holds OUT_VALID high while it has a head word and keeps
// OUT_DATA/OUT_SOF/OUT_EOL unchanged until that word is taken. A word is taken
// on every rising clock edge where OUT_VALID and OUT_READY are both high.
// OUT_READY may be asserted or withdrawn at any time and does not depend on
// OUT_VALID.
interface naneye_pixel_packer_if;
  logic [15:0] OUT_DATA;
  logic        OUT_SOF;
  logic        OUT_EOL;
  logic        OUT_VALID;
  logic        OUT_READY;

  modport master (
    output OUT_DATA,
    output OUT_SOF,
    output OUT_EOL,
    output OUT_VALID,
    input  OUT_READY
  );

  modport slave (
    input  OUT_DATA,
    input  OUT_SOF,
    input  OUT_EOL,
    input  OUT_VALID,
    output OUT_READY
  );
endinterface

// File: rtl/naneye_pixel_packer.sv
// Packs 10-bit NanEye pixels LSB-first into 16-bit words (8 pixels -> 5 words),
// tags start-of-frame / end-of-line, and buffers the words in a first-word-
// fall-through FIFO. Also tracks line length, word loss and frame count.
module naneye_pixel_packer #(
  parameter int D_WIDTH    = 10,
  parameter int C_COLUMNS  = 320,
  parameter int C_ROWS     = 320,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 FRAME_START,
  input  logic [D_WIDTH-1:0]   PIX_DATA,
  input  logic                 PIX_EN,
  input  logic                 LINE_END,
  naneye_pixel_packer_if.master stream,
  output logic                 OVERFLOW,
  output logic                 LINE_ERR,
  output logic [15:0]          FRAME_CNT,
  output logic [1:0]           state_dbg
);

  localparam int CW = $clog2(C_COLUMNS + 1);
  localparam int RW = $clog2(C_ROWS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DROP   = 2'd2
  } state_t;

  state_t state, state_nx;

  // Packing state: acc holds the n (0..15) not-yet-emitted bits.
  logic [15:0]   acc;
  logic [4:0]    n;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          sof_pend;
  logic          flush_pend;

  // Last word of a line whose EOL flag is resolved in the flush cycle.
  logic          hold_vld;
  logic [15:0]   hold_data;

  // One-entry push stage in front of the FIFO.
  logic          push_vld;
  logic [15:0]   push_data;
  logic          push_sof;
  logic          push_eol;

  logic          overflow;
  logic          line_err;
  logic [15:0]   frame_cnt;

  // FIFO storage.
  logic [17:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic [25:0]   sum;
  logic [4:0]    n_sum;
  logic          word_done;
  logic          pix_take;
  logic          last_pix;
  logic          line_short;
  logic          do_flush;
  logic          fifo_valid;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;
  logic          push_lost;
  logic [17:0]   head;

  assign sum        = 26'(acc) | (26'(PIX_DATA) << n);
  assign n_sum      = n + 5'd10;
  assign word_done  = (n_sum >= 5'd16);
  assign pix_take   = PIX_EN && (state == ACTIVE);
  assign last_pix   = (col == CW'(C_COLUMNS - 1));
  assign line_short = LINE_END && (state == ACTIVE) && (col != '0) && (col < CW'(C_COLUMNS));
  assign do_flush   = flush_pend && (state == ACTIVE);

  assign fifo_valid = (count != '0);
  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign pop        = fifo_valid && stream.OUT_READY;
  assign push_ok    = push_vld && (!fifo_full || pop);
  assign push_lost  = push_vld && fifo_full && !pop;
  assign head       = mem[rd_ptr];

  // Outputs are forced to zero while the FIFO is empty so reset shows all zeros.
  assign stream.OUT_VALID = fifo_valid;
  assign stream.OUT_DATA  = fifo_valid ? head[15:0] : 16'd0;
  assign stream.OUT_EOL   = fifo_valid ? head[16]   : 1'b0;
  assign stream.OUT_SOF   = fifo_valid ? head[17]   : 1'b0;

  assign OVERFLOW  = overflow;
  assign LINE_ERR  = line_err;
  assign FRAME_CNT = frame_cnt;
  assign state_dbg = state;

  // State register.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state: FRAME_START wins, then word loss, then end of the last row.
  always_comb begin
    state_nx = state;
    if (FRAME_START) begin
      state_nx = ACTIVE;
    end else if (push_lost) begin
      state_nx = DROP;
    end else if (do_flush && (row == RW'(C_ROWS - 1))) begin
      state_nx = IDLE;
    end
  end

  // Packing, line flush, push stage and status registers.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      acc        <= '0;
      n          <= '0;
      col        <= '0;
      row        <= '0;
      sof_pend   <= 1'b0;
      flush_pend <= 1'b0;
      hold_vld   <= 1'b0;
      hold_data  <= '0;
      push_vld   <= 1'b0;
      push_data  <= '0;
      push_sof   <= 1'b0;
      push_eol   <= 1'b0;
      overflow   <= 1'b0;
      line_err   <= 1'b0;
      frame_cnt  <= '0;
    end else if (FRAME_START) begin
      // Any partial word of the previous frame is dropped here.
      acc        <= '0;
      n          <= '0;
      col        <= '0;
      row        <= '0;
      sof_pend   <= 1'b1;
      flush_pend <= 1'b0;
      hold_vld   <= 1'b0;
      push_vld   <= 1'b0;
      overflow   <= 1'b0;
      line_err   <= 1'b0;
      frame_cnt  <= frame_cnt + 16'd1;
    end else begin
      push_vld <= 1'b0;
      if (push_lost) overflow <= 1'b1;

      if (line_short) begin
        line_err   <= 1'b1;
        flush_pend <= 1'b1;
      end

      if (pix_take) begin
        col <= col + CW'(1);
        if (last_pix) flush_pend <= 1'b1;
        if (word_done) begin
          acc <= {6'd0, sum[25:16]};
          n   <= n_sum - 5'd16;
          if (last_pix && (n_sum == 5'd16)) begin
            hold_vld  <= 1'b1;
            hold_data <= sum[15:0];
          end else begin
            push_vld  <= 1'b1;
            push_data <= sum[15:0];
            push_eol  <= 1'b0;
            push_sof  <= sof_pend;
            sof_pend  <= 1'b0;
          end
        end else begin
          acc <= sum[15:0];
          n   <= n_sum;
        end
      end

      if (do_flush) begin
        flush_pend <= 1'b0;
        hold_vld   <= 1'b0;
        acc        <= '0;
        n          <= '0;
        col        <= '0;
        row        <= row + RW'(1);
        if (hold_vld) begin
          push_vld  <= 1'b1;
          push_data <= hold_data;
          push_eol  <= 1'b1;
          push_sof  <= sof_pend;
          sof_pend  <= 1'b0;
        end else if (n != 5'd0) begin
          push_vld  <= 1'b1;
          push_data <= acc;
          push_eol  <= 1'b1;
          push_sof  <= sof_pend;
          sof_pend  <= 1'b0;
        end
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write; contents need no reset since they are gated by count.
  always_ff @(posedge CLOCK) begin
    if (push_ok) mem[wr_ptr] <= {push_sof, push_eol, push_data};
  end

endmodule

// File: tb/tb_naneye_pixel_packer.sv
// Directed bench for naneye_pixel_packer: single line packing, short line,
// frame row limit, backpressure, overflow and reset/restart.
module tb_naneye_pixel_packer;

  localparam int W = 18;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DROP   = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       frame_start = 1'b0;
  logic       pix_en      = 1'b0;
  logic       line_end    = 1'b0;
  logic [9:0] pix_data    = '0;
  logic       ready       = 1'b0;
  logic       sel_b       = 1'b0;

  logic        ovf_a, lerr_a, ovf_b, lerr_b;
  logic [15:0] fcnt_a, fcnt_b;
  logic [1:0]  st_a, st_b;

  naneye_pixel_packer_if if_a ();
  naneye_pixel_packer_if if_b ();
  assign if_a.OUT_READY = ready;
  assign if_b.OUT_READY = ready;

  naneye_pixel_packer #(.D_WIDTH(10), .C_COLUMNS(320), .C_ROWS(320), .FIFO_DEPTH(64)) dut_a (
    .CLOCK(clk), .RESET(rst_n),
    .FRAME_START(frame_start & ~sel_b), .PIX_DATA(pix_data),
    .PIX_EN(pix_en & ~sel_b), .LINE_END(line_end & ~sel_b),
    .stream(if_a), .OVERFLOW(ovf_a), .LINE_ERR(lerr_a),
    .FRAME_CNT(fcnt_a), .state_dbg(st_a)
  );

  naneye_pixel_packer #(.D_WIDTH(10), .C_COLUMNS(8), .C_ROWS(2), .FIFO_DEPTH(64)) dut_b (
    .CLOCK(clk), .RESET(rst_n),
    .FRAME_START(frame_start & sel_b), .PIX_DATA(pix_data),
    .PIX_EN(pix_en & sel_b), .LINE_END(line_end & sel_b),
    .stream(if_b), .OVERFLOW(ovf_b), .LINE_ERR(lerr_b),
    .FRAME_CNT(fcnt_b), .state_dbg(st_b)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_a[$];
  logic [W-1:0] got_b[$];
  int n_checks = 0;
  int n_pass   = 0;
  bit live_chk = 1'b0;
  int pop_idx  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Collect popped words; during the backpressure run also check the head
  // word against the model every cycle it is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      if (live_chk && if_a.OUT_VALID) begin
        if (pop_idx < exp_q.size())
          check("bp_head", {if_a.OUT_SOF, if_a.OUT_EOL, if_a.OUT_DATA}, exp_q[pop_idx]);
        else
          check("bp_extra", pop_idx, exp_q.size());
        if (ready) pop_idx++;
      end
      if (if_a.OUT_VALID && ready) got_a.push_back({if_a.OUT_SOF, if_a.OUT_EOL, if_a.OUT_DATA});
      if (if_b.OUT_VALID && ready) got_b.push_back({if_b.OUT_SOF, if_b.OUT_EOL, if_b.OUT_DATA});
    end
  end

  // ---------------- model ----------------
  function automatic logic [9:0] pix_val(input int kind, input int i);
    case (kind)
      0:       return 10'((i + 1) % 1024);
      1:       return 10'((i * 37 + 5) % 1024);
      2:       return 10'h3FF;
      default: return 10'((i * 731 + 99) % 1024);
    endcase
  endfunction

  // Bit-serial reference: lay pixel bits out one by one, cut every 16 bits.
  task automatic model_line(input int kind, input int base, input int npix, input bit sof);
    logic [15:0]  w;
    logic [9:0]   p;
    logic [W-1:0] t;
    int nb;
    bit first;
    w = '0; nb = 0; first = sof;
    for (int i = 0; i < npix; i++) begin
      p = pix_val(kind, base + i);
      for (int b = 0; b < 10; b++) begin
        w[nb] = p[b];
        nb++;
        if (nb == 16) begin
          exp_q.push_back({first, 1'b0, w});
          first = 1'b0; nb = 0; w = '0;
        end
      end
    end
    if (nb > 0) begin
      exp_q.push_back({first, 1'b1, w});
    end else begin
      t = exp_q.pop_back();
      t[16] = 1'b1;
      exp_q.push_back(t);
    end
  endtask

  task automatic compare_a(input string tag);
    int m;
    check({tag, "_count"}, got_a.size(), exp_q.size());
    m = (got_a.size() < exp_q.size()) ? got_a.size() : exp_q.size();
    for (int i = 0; i < m; i++) check($sformatf("%s[%0d]", tag, i), got_a[i], exp_q[i]);
    got_a.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send_pixel(input logic [9:0] v);
    pix_data = v;
    pix_en   = 1'b1;
    tick();
    pix_en   = 1'b0;
    tick();
  endtask

  task automatic pulse_line_end();
    line_end = 1'b1;
    tick();
    line_end = 1'b0;
    tick();
  endtask

  task automatic send_line(input int kind, input int base, input int npix);
    for (int i = 0; i < npix; i++) send_pixel(pix_val(kind, base + i));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation did not finish");
  end

  // ---------------- main sequence ----------------
  bit bp_on;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", if_a.OUT_VALID, 0);
    check("rst_data", if_a.OUT_DATA, 0);
    check("rst_sof", if_a.OUT_SOF, 0);
    check("rst_eol", if_a.OUT_EOL, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_lerr", lerr_a, 0);
    check("rst_fcnt", fcnt_a, 0);
    check("rst_state", st_a, ST_IDLE);
    rst_n = 1'b1;
    tick();

    // Frame limit on the 8x2 instance: third line must be ignored.
    sel_b = 1'b1;
    ready = 1'b1;
    pulse_frame();
    check("lim_fcnt_next", fcnt_b, 1);
    for (int l = 0; l < 3; l++) begin
      send_line(1, l * 8, 8);
      pulse_line_end();
    end
    wait_cycles(10);
    check("lim_count", got_b.size(), 10);
    if (got_b.size() == 10) begin
      check("lim_w0", got_b[0], {2'b10, 16'(10'd5) | 16'(16'd42 << 10)});
      check("lim_eol4", got_b[4][17:16], 2'b01);
      check("lim_eol9", got_b[9][17:16], 2'b01);
      check("lim_eol3", got_b[3][16], 0);
      check("lim_w5_sof", got_b[5][17], 0);
    end
    model_line(1, 0, 8, 1'b1);
    model_line(1, 8, 8, 1'b0);
    for (int i = 0; i < 10 && i < got_b.size(); i++) check($sformatf("lim[%0d]", i), got_b[i], exp_q[i]);
    exp_q.delete();
    got_b.delete();
    check("lim_state", st_b, ST_IDLE);
    check("lim_fcnt", fcnt_b, 1);
    sel_b = 1'b0;
    tick();

    // Single 320-pixel line, values 1..320, with first-word latency.
    pulse_frame();
    check("l1_fcnt", fcnt_a, 1);
    check("l1_state", st_a, ST_ACTIVE);
    model_line(0, 0, 320, 1'b1);
    send_pixel(10'd1);
    pix_data = 10'd2;
    pix_en   = 1'b1;
    tick();
    pix_en   = 1'b0;
    check("lat_t1_valid", if_a.OUT_VALID, 0);
    tick();
    check("lat_t2_valid", if_a.OUT_VALID, 1);
    send_line(0, 2, 318);
    wait_cycles(10);
    if (got_a.size() >= 2) begin
      check("l1_word0", got_a[0], 18'h20801);
      check("l1_word1", got_a[1], 18'h00030);
    end
    if (got_a.size() == 200) check("l1_word199_flags", got_a[199][17:16], 2'b01);
    compare_a("line1");

    // Short line of five 0x3FF pixels, then a full line from column 0.
    pulse_frame();
    check("sl_fcnt", fcnt_a, 2);
    exp_q.push_back(18'h2FFFF);
    exp_q.push_back(18'h0FFFF);
    exp_q.push_back(18'h0FFFF);
    exp_q.push_back(18'h10003);
    send_line(2, 0, 5);
    check("sl_lerr_before", lerr_a, 0);
    pulse_line_end();
    check("sl_lerr", lerr_a, 1);
    wait_cycles(6);
    compare_a("short");
    model_line(1, 0, 320, 1'b0);
    send_line(1, 0, 320);
    wait_cycles(10);
    compare_a("after_short");
    check("sl_lerr_sticky", lerr_a, 1);

    // Backpressure: random OUT_READY during a full line.
    pulse_frame();
    check("bp_fcnt", fcnt_a, 3);
    check("bp_lerr_clr", lerr_a, 0);
    model_line(3, 0, 320, 1'b1);
    pop_idx  = 0;
    live_chk = 1'b1;
    bp_on    = 1'b1;
    fork
      begin
        send_line(3, 0, 320);
        bp_on = 1'b0;
      end
      begin
        while (bp_on) begin
          ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    ready = 1'b1;
    wait_cycles(150);
    live_chk = 1'b0;
    check("bp_ovf", ovf_a, 0);
    compare_a("bp");

    // Overflow: no pops, FIFO fills to 64 then the block drops the frame.
    ready = 1'b0;
    pulse_frame();
    check("ov_fcnt", fcnt_a, 4);
    model_line(0, 0, 320, 1'b1);
    while (exp_q.size() > 64) void'(exp_q.pop_back());
    send_line(0, 0, 320);
    check("ov_flag", ovf_a, 1);
    check("ov_state", st_a, ST_DROP);
    send_line(1, 0, 4);
    check("ov_still_drop", st_a, ST_DROP);
    pulse_frame();
    check("ov_fcnt2", fcnt_a, 5);
    check("ov_clr", ovf_a, 0);
    check("ov_state2", st_a, ST_ACTIVE);
    ready = 1'b1;
    send_pixel(10'h155);
    send_pixel(10'h2AA);
    exp_q.push_back(18'h2A955);
    wait_cycles(90);
    compare_a("ovf");

    // Reset mid-line with a partial accumulator, then restart.
    ready = 1'b0;
    pulse_frame();
    check("rs_fcnt", fcnt_a, 6);
    send_line(2, 0, 3);
    check("rs_valid_before", if_a.OUT_VALID, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_valid", if_a.OUT_VALID, 0);
    check("rs_data", if_a.OUT_DATA, 0);
    check("rs_sof", if_a.OUT_SOF, 0);
    check("rs_eol", if_a.OUT_EOL, 0);
    check("rs_ovf", ovf_a, 0);
    check("rs_lerr", lerr_a, 0);
    check("rs_fcnt", fcnt_a, 0);
    check("rs_state", st_a, ST_IDLE);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_frame();
    check("rs_fcnt_restart", fcnt_a, 1);
    ready = 1'b1;
    send_pixel(10'd1);
    send_pixel(10'd0);
    exp_q.push_back(18'h20001);
    wait_cycles(6);
    compare_a("restart");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
